dcache_direct_mapped: RTL
=========================

Name: dcache_direct_mapped

Overview:
- Direct-mapped, write-back, write-allocate data cache between the pipeline MEM stage and the block-granular data memory.
- Serves 32-bit word loads and stores in one cycle on a hit.
- On a miss, writes back the dirty victim line, fetches the missing line as one block transaction, then returns to lookup.
- Exposes hit and miss counters for CPI analysis.

Parameters:
- LINE_SIZE, 16, bytes per line; must equal the memory BLOCK_SIZE.
- NUM_SETS, 16, number of lines (index width = log2).
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- is_input_valid  in  1  CPU request valid
- addr  in  32  CPU byte address, word aligned
- mem_read  in  1  load request
- mem_write  in  1  store request
- din  in  32  store data
- is_ready  out  1  cache can accept a lookup (state IDLE)
- is_output_valid  out  1  dout valid / store committed this cycle
- dout  out  32  load data
- is_hit  out  1  lookup hit (combinational)
- dmem_is_input_valid  out  1  memory request valid
- dmem_addr  out  32  block index = byte address >> log2(LINE_SIZE)
- dmem_read  out  1  block read
- dmem_write  out  1  block write
- dmem_din  out  LINE_SIZE*8  victim line
- dmem_is_output_valid  in  1  fill data valid
- dmem_dout  in  LINE_SIZE*8  fill line
- dmem_ready  in  1  memory idle
- hit_count  out  CNT_WIDTH  hits since reset
- miss_count  out  CNT_WIDTH  misses since reset

Behaviour:
- Address split at defaults: offset [3:0], word select [3:2], index [7:4], tag [31:8]. Each line stores valid, dirty, tag and data.
- Reset (synchronous):
  - all valid and dirty bits cleared; state IDLE; counters 0.
  - all dmem_* outputs 0; is_output_valid 0; dout 0.
  - Reset mid-miss abandons the transaction; dirty data is lost by definition.
- Lookup: is_hit = is_input_valid & (mem_read|mem_write) & valid[idx] & tag match.
- IDLE hit:
  - Read: is_output_valid = 1 and dout = selected word, same cycle.
  - Write: is_output_valid = 1; the word is written at the next edge and dirty is set.
  - hit_count increments at that edge.
- IDLE miss: miss_count increments; next state is WB_REQ if the victim is valid and dirty, else ALLOC_REQ. is_ready drops the next cycle.
- The CPU holds its request unchanged until is_output_valid. After a fill the cache re-looks up in IDLE and hits. The miss counts once; the retry hit counts once.
- WB_REQ:
  - Drive dmem_is_input_valid = 1, dmem_write = 1, dmem_addr = {victim tag, idx}, dmem_din = victim line.
  - When dmem_ready = 1 the request is accepted at the edge; go to WB_WAIT.
- WB_WAIT: all dmem_* outputs 0. When dmem_ready returns to 1, the write commits at that edge; go to ALLOC_REQ.
- ALLOC_REQ: drive dmem_is_input_valid = 1, dmem_read = 1, dmem_addr = addr >> 4. When dmem_ready = 1, go to ALLOC_WAIT.
- ALLOC_WAIT: on dmem_is_output_valid, write the line, set valid = 1, dirty = 0, tag = new tag; go to IDLE.
- Requests with neither mem_read nor mem_write, or with is_input_valid = 0, are ignored and not counted.
- mem_read and mem_write both high is illegal; a store takes priority.
- Counters wrap at 2^CNT_WIDTH.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, WB_REQ, WB_WAIT, ALLOC_REQ, ALLOC_WAIT)
  - LINE_SIZE and NUM_SETS defaults
  - offset, index and tag width constants derived via CLOG2
- One natural sub-module: dcache_line_array (valid/dirty/tag/data storage with word-write and line-fill ports).
- The FSM and counters live in the top module.

Test Plan (with DataMemory DELAY = 50):
- Cold read miss at 0x100 after reset → is_output_valid rises exactly DELAY+3 = 53 cycles after the request is presented, dout = mem block 0x10 word 0; miss_count = 1, hit_count = 1.
- Store 0xDEADBEEF to 0x104, then load 0x104 → load hits in one cycle returning 0xDEADBEEF with no dmem request issued.
- Dirty eviction: store to 0x104, then load 0x1104 (same index 0, different tag) → write to block 0x10 carrying 0xDEADBEEF in word 1, then read of block 0x110; load completes 2*DELAY+5 = 105 cycles after presentation.
- Clean conflict miss: load 0x200 then 0x1200 → no write issued, only a block read; dirty bit remains 0.
- Reset asserted while in ALLOC_WAIT → next cycle state IDLE, is_ready = 1, all lines invalid, counters 0, dmem_is_input_valid = 0.
- 32 consecutive word loads over 0x0–0x7C → miss_count = 8, hit_count = 32.

Source files
------------

// File: rtl/dcache_direct_mapped_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dcache_direct_mapped_pkg;

    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;

    // Default geometry: one cache line equals one memory block.
    localparam int DEF_LINE_SIZE = 16;
    localparam int DEF_NUM_SETS  = 16;

    // Address split derived from the default geometry.
    localparam int DEF_OFFSET_W = $clog2(DEF_LINE_SIZE);
    localparam int DEF_INDEX_W  = $clog2(DEF_NUM_SETS);
    localparam int DEF_TAG_W    = ADDR_W - DEF_OFFSET_W - DEF_INDEX_W;

    // Miss handling walks WB_REQ/WB_WAIT only when the victim is dirty.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WB_REQ     = 3'd1,
        ST_WB_WAIT    = 3'd2,
        ST_ALLOC_REQ  = 3'd3,
        ST_ALLOC_WAIT = 3'd4
    } state_t;

endpackage

// File: rtl/dcache_line_array.sv
// Line storage: valid/dirty/tag/data per set, one word-write port and one line-fill port.
// Latency: reads are combinational on idx; writes land at the next clock edge.
// Backpressure: none; the controller sequences word writes and fills.
module dcache_line_array
    import dcache_direct_mapped_pkg::*;
#(
    parameter int LINE_SIZE = DEF_LINE_SIZE,
    parameter int NUM_SETS  = DEF_NUM_SETS,
    parameter int TAG_W     = DEF_TAG_W,
    localparam int INDEX_W  = $clog2(NUM_SETS),
    localparam int WORDS    = LINE_SIZE / 4,
    localparam int WSEL_W   = $clog2(WORDS),
    localparam int LINE_W   = LINE_SIZE * 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] idx,
    input  logic               word_we,
    input  logic [WSEL_W-1:0]  word_sel,
    input  logic [WORD_W-1:0]  word_dat,
    input  logic               fill_en,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic [LINE_W-1:0]  fill_line,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [LINE_W-1:0]  rd_line
);

    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [WORD_W-1:0]   data_q [NUM_SETS][WORDS];

    // Status bits: reset invalidates everything; a fill yields a clean line, a store dirties it.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (word_we) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag and data payload; contents are meaningless while the valid bit is clear, so no reset.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[idx] <= fill_tag;
            for (int w = 0; w < WORDS; w++) begin
                data_q[idx][w] <= fill_line[w*WORD_W +: WORD_W];
            end
        end else if (word_we) begin
            data_q[idx][word_sel] <= word_dat;
        end
    end

    // Combinational lookup of the addressed set, also used as the writeback victim.
    always_comb begin
        rd_valid = valid_q[idx];
        rd_dirty = dirty_q[idx];
        rd_tag   = tag_q[idx];
        rd_line  = '0;
        for (int w = 0; w < WORDS; w++) begin
            rd_line[w*WORD_W +: WORD_W] = data_q[idx][w];
        end
    end

endmodule

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-back, write-allocate data cache between the MEM stage and block memory.
// Latency: hits answer in the same cycle; misses write back a dirty victim, fill, then re-look up.
// Backpressure: is_ready drops during a miss; CPU holds its request until is_output_valid; memory gated by dmem_ready.
module dcache_direct_mapped
    import dcache_direct_mapped_pkg::*;
#(
    parameter int LINE_SIZE = DEF_LINE_SIZE,
    parameter int NUM_SETS  = DEF_NUM_SETS,
    parameter int CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   is_input_valid,
    input  logic [ADDR_W-1:0]      addr,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [WORD_W-1:0]      din,
    output logic                   is_ready,
    output logic                   is_output_valid,
    output logic [WORD_W-1:0]      dout,
    output logic                   is_hit,
    output logic                   dmem_is_input_valid,
    output logic [ADDR_W-1:0]      dmem_addr,
    output logic                   dmem_read,
    output logic                   dmem_write,
    output logic [LINE_SIZE*8-1:0] dmem_din,
    input  logic                   dmem_is_output_valid,
    input  logic [LINE_SIZE*8-1:0] dmem_dout,
    input  logic                   dmem_ready,
    output logic [CNT_WIDTH-1:0]   hit_count,
    output logic [CNT_WIDTH-1:0]   miss_count
);

    localparam int OFFSET_W = $clog2(LINE_SIZE);
    localparam int INDEX_W  = $clog2(NUM_SETS);
    localparam int TAG_W    = ADDR_W - OFFSET_W - INDEX_W;
    localparam int WORDS    = LINE_SIZE / 4;
    localparam int WSEL_W   = $clog2(WORDS);
    localparam int LINE_W   = LINE_SIZE * 8;

    state_t              state;

    logic [INDEX_W-1:0]  req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [WSEL_W-1:0]   req_wsel;
    logic [ADDR_W-1:0]   fill_blk_addr;
    logic                req_vld;
    logic                serve;
    logic                word_we;
    logic                fill_en;

    logic                rd_valid;
    logic                rd_dirty;
    logic [TAG_W-1:0]    rd_tag;
    logic [LINE_W-1:0]   rd_line;

    assign req_idx       = addr[OFFSET_W +: INDEX_W];
    assign req_tag       = addr[ADDR_W-1 -: TAG_W];
    assign req_wsel      = addr[2 +: WSEL_W];
    assign fill_blk_addr = addr >> OFFSET_W;

    // A request with neither read nor write is a bubble and never counted.
    assign req_vld = is_input_valid & (mem_read | mem_write);
    assign is_hit  = req_vld & rd_valid & (rd_tag == req_tag);

    // Hits are only served from IDLE; elsewhere the array is mid-miss.
    assign serve           = (state == ST_IDLE) & is_hit & ~reset;
    assign word_we         = serve & mem_write;
    assign fill_en         = (state == ST_ALLOC_WAIT) & dmem_is_output_valid & ~reset;
    assign is_output_valid = serve;

    dcache_line_array #(
        .LINE_SIZE (LINE_SIZE),
        .NUM_SETS  (NUM_SETS),
        .TAG_W     (TAG_W)
    ) u_lines (
        .clk       (clk),
        .reset     (reset),
        .idx       (req_idx),
        .word_we   (word_we),
        .word_sel  (req_wsel),
        .word_dat  (din),
        .fill_en   (fill_en),
        .fill_tag  (req_tag),
        .fill_line (dmem_dout),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line)
    );

    // Load data: selected word on a read hit, zero otherwise (stores take priority over loads).
    always_comb begin
        dout = '0;
        if (serve && !mem_write) begin
            dout = rd_line[req_wsel*WORD_W +: WORD_W];
        end
    end

    // Miss FSM with registered memory-side outputs, plus the hit/miss statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= ST_IDLE;
            is_ready            <= 1'b1;
            dmem_is_input_valid <= 1'b0;
            dmem_addr           <= '0;
            dmem_read           <= 1'b0;
            dmem_write          <= 1'b0;
            dmem_din            <= '0;
            hit_count           <= '0;
            miss_count          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_vld) begin
                        if (is_hit) begin
                            hit_count <= hit_count + CNT_WIDTH'(1);
                        end else begin
                            miss_count          <= miss_count + CNT_WIDTH'(1);
                            is_ready            <= 1'b0;
                            dmem_is_input_valid <= 1'b1;
                            if (rd_valid && rd_dirty) begin
                                // Victim goes back to its own block address before the fill.
                                state      <= ST_WB_REQ;
                                dmem_write <= 1'b1;
                                dmem_addr  <= ADDR_W'({rd_tag, req_idx});
                                dmem_din   <= rd_line;
                            end else begin
                                state     <= ST_ALLOC_REQ;
                                dmem_read <= 1'b1;
                                dmem_addr <= fill_blk_addr;
                            end
                        end
                    end
                end
                ST_WB_REQ: begin
                    if (dmem_ready) begin
                        state               <= ST_WB_WAIT;
                        dmem_is_input_valid <= 1'b0;
                        dmem_write          <= 1'b0;
                        dmem_addr           <= '0;
                        dmem_din            <= '0;
                    end
                end
                ST_WB_WAIT: begin
                    // Memory returning to ready means the writeback has committed.
                    if (dmem_ready) begin
                        state               <= ST_ALLOC_REQ;
                        dmem_is_input_valid <= 1'b1;
                        dmem_read           <= 1'b1;
                        dmem_addr           <= fill_blk_addr;
                    end
                end
                ST_ALLOC_REQ: begin
                    if (dmem_ready) begin
                        state               <= ST_ALLOC_WAIT;
                        dmem_is_input_valid <= 1'b0;
                        dmem_read           <= 1'b0;
                        dmem_addr           <= '0;
                    end
                end
                ST_ALLOC_WAIT: begin
                    // Fill lands this edge; the held request re-looks up and hits in IDLE.
                    if (dmem_is_output_valid) begin
                        state    <= ST_IDLE;
                        is_ready <= 1'b1;
                    end
                end
                default: begin
                    state               <= ST_IDLE;
                    is_ready            <= 1'b1;
                    dmem_is_input_valid <= 1'b0;
                    dmem_read           <= 1'b0;
                    dmem_write          <= 1'b0;
                    dmem_addr           <= '0;
                    dmem_din            <= '0;
                end
            endcase
        end
    end

endmodule
